ingress_arbiter: RTL and testbench
==================================

# ingress_arbiter

Round-robin read-side controller for the three 4096×32 input RAMs that the host loads through addresses 1–3. It tracks per-port occupancy and drives each RAM's read port, granting one port at a time for bursts of up to `BURST` words. It presents each word to the downstream packet buffer over a valid/ready handshake, tagged with its source port. It sits between the input RAMs and the buffer/scheduler stage and replaces ad-hoc read-address stepping.

## Interface
- `ADDR_W`, 12, RAM address width; depth is 2^ADDR_W.
- `DATA_W`, 32, word width.
- `BURST`, 4, maximum words per grant; legal range 1–15.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  host read-enable; when low, no new grant or burst word is started.
- `push`  in  3  bit n pulses for one cycle, coincident with the write-enable of RAM n+1; one word added.
- `ram_rden`  out  3  read enable to RAM n+1; at most one bit high.
- `ram_rd_add1`, `ram_rd_add2`, `ram_rd_add3`  out  ADDR_W  read address per RAM; held at that port's read pointer.
- `ram_q1`, `ram_q2`, `ram_q3`  in  DATA_W  RAM read data; valid the cycle after the `rden` cycle.
- `out_data`  out  DATA_W  forwarded word.
- `out_port`  out  2  source port of `out_data`: 0, 1 or 2.
- `out_valid`  out  1  `out_data` and `out_port` valid.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `occupancy1`, `occupancy2`, `occupancy3`  out  ADDR_W+1  words pending per port.
- `overflow`  out  3  sticky; bit n set on a push to port n while that port is full.

## Operation
- Per-port state:
  - read pointer `rd_ptr[n]` (ADDR_W bits) wraps modulo 2^ADDR_W with no special case.
  - count `cnt[n]` (ADDR_W+1 bits), range 0..2^ADDR_W.
- Count update:
  - push only: +1.
  - pop only: −1. A pop is the ISSUE cycle for port n.
  - push and pop in the same cycle: unchanged.
  - push when `cnt[n]`==2^ADDR_W and no pop that cycle: count unchanged, `overflow[n]` set. `overflow[n]` clears only on reset.
- Pops are issued only when `cnt[n]`>0, so count never underflows.
- FSM states: IDLE, ISSUE, CAPTURE, HOLD.
  - IDLE: if `enable` and any `cnt`>0, grant the first non-empty port in order `last+1`, `last+2`, `last` (mod 3). Set `burst_cnt`=0 and go to ISSUE. Otherwise stay.
  - ISSUE: assert `ram_rden[g]` with address `rd_ptr[g]`; `rd_ptr[g]`++; pop. Go to CAPTURE.
  - CAPTURE: latch `ram_q(g+1)` into `out_data` and `g` into `out_port`; set `out_valid`. Go to HOLD.
  - HOLD: on `out_ready`, clear `out_valid` and `burst_cnt`++. Then:
    - if the incremented `burst_cnt` < `BURST`, `enable`=1 and `cnt[g]`>0: go to ISSUE for the same port.
    - else: `last`=g, go to IDLE.
    - Without `out_ready`: hold data and port stable.
- `enable` falling mid-burst: the in-flight word completes normally; return to IDLE after its handshake.
- Reset values:
  - state IDLE, `last`=2 (port 0 wins first).
  - `rd_ptr`=0, `cnt`=0, `overflow`=0.
  - `out_valid`=0, `out_data`=0, `out_port`=0, `ram_rden`=0.
  - A reset mid-burst abandons the word. Its pop is not undone.

## Timing
- Push at edge N: occupancy visible after N.
- Earliest ISSUE is the cycle after IDLE sees the count.
- Latency with an idle arbiter: push at edge N → `rden` high during cycle N+1..N+2 → `out_valid` high from edge N+3.
- Per-word throughput: 3 cycles (ISSUE, CAPTURE, HOLD) with `out_ready` held high. Grant change adds 1 IDLE cycle.
- `ram_rden` is high for exactly one cycle per word.
- Read address and `ram_rden` are registered outputs.
- `out_valid` never drops without a handshake, except on reset.

## Test plan
- Reset, push 1 word to port 0 (data 0xA5A5_0001), `out_ready`=1, `enable`=1 → `out_valid` at edge N+3, `out_data`=0xA5A5_0001, `out_port`=0, `occupancy1` returns to 0.
- 6 words on each port, `BURST`=4 → order is port0 ×4, port1 ×4, port2 ×4, port0 ×2, port1 ×2, port2 ×2; data in FIFO order per port.
- Hold `out_ready` low for 10 cycles during HOLD → `out_data`/`out_port` stable, no extra `rden`, then release → next word follows.
- Fill port 1 with 4096 pushes, push once more → `occupancy2`=4096, `overflow`=3'b010. Drain 4097 pushes' worth → only 4096 words out, and read pointer wraps to 0.
- Push and pop on port 2 in the same cycle → `occupancy3` unchanged; `enable` dropped mid-burst → current word delivered, next grant waits for `enable`.
- Assert `reset` during CAPTURE → next cycle `out_valid`=0, all occupancies 0, `overflow`=0; next grant goes to port 0.

Source files
------------

// File: rtl/ingress_arbiter.sv
// ingress_arbiter: round-robin burst reader for the three input RAMs.
// Tracks per-port occupancy, drives each RAM read port and forwards words
// downstream over valid/ready, tagged with the source port.
module ingress_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        push,
  output logic [2:0]        ram_rden,
  output logic [ADDR_W-1:0] ram_rd_add1,
  output logic [ADDR_W-1:0] ram_rd_add2,
  output logic [ADDR_W-1:0] ram_rd_add3,
  input  logic [DATA_W-1:0] ram_q1,
  input  logic [DATA_W-1:0] ram_q2,
  input  logic [DATA_W-1:0] ram_q3,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_port,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   occupancy1,
  output logic [ADDR_W:0]   occupancy2,
  output logic [ADDR_W:0]   occupancy3,
  output logic [2:0]        overflow
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned BCNT_W = 4;
  localparam logic [CNT_W-1:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_e;

  state_e              state_q;
  logic [1:0]          grant_q;
  logic [1:0]          last_q;
  logic [BCNT_W-1:0]   burst_q;
  logic [2:0]          ram_rden_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [1:0]          out_port_q;
  logic                out_valid_q;
  logic [ADDR_W-1:0]   rd_ptr_q [3];
  logic [CNT_W-1:0]    cnt_q [3];
  logic [CNT_W-1:0]    cnt_d [3];
  logic [2:0]          ovf_q;
  logic [2:0]          ovf_d;
  logic [2:0]          pop;
  logic [2:0]          nz;
  logic [1:0]          cand1;
  logic [1:0]          cand2;
  logic [1:0]          pick;
  logic [BCNT_W-1:0]   burst_inc;
  logic                burst_more;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Pop strobe, non-empty flags and next count/overflow per port
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      pop[n]   = (state_q == ISSUE) && (grant_q == 2'(n));
      nz[n]    = (cnt_q[n] != '0);
      cnt_d[n] = cnt_q[n];
      ovf_d[n] = ovf_q[n];
      if (push[n] && !pop[n]) begin
        if (cnt_q[n] == FULL) ovf_d[n] = 1'b1;
        else                  cnt_d[n] = cnt_q[n] + CNT_W'(1);
      end else if (!push[n] && pop[n]) begin
        cnt_d[n] = cnt_q[n] - CNT_W'(1);
      end
    end
  end

  // Round-robin candidate pick and burst continuation decision
  always_comb begin
    cand1 = inc3(last_q);
    cand2 = inc3(cand1);
    if (nz[cand1])      pick = cand1;
    else if (nz[cand2]) pick = cand2;
    else                pick = last_q;
    burst_inc  = burst_q + BCNT_W'(1);
    burst_more = (burst_inc < BCNT_W'(BURST)) && enable && nz[grant_q];
  end

  // Per-port read pointers, occupancy counts and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 3; n++) begin
        rd_ptr_q[n] <= '0;
        cnt_q[n]    <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        cnt_q[n] <= cnt_d[n];
        if (pop[n]) rd_ptr_q[n] <= rd_ptr_q[n] + ADDR_W'(1);
      end
      ovf_q <= ovf_d;
    end
  end

  // Grant FSM with registered read enables and output word
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 2'd0;
      last_q      <= 2'd2;
      burst_q     <= '0;
      ram_rden_q  <= '0;
      out_data_q  <= '0;
      out_port_q  <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      ram_rden_q <= '0;
      case (state_q)
        IDLE: begin
          if (enable && (nz != 3'b000)) begin
            grant_q    <= pick;
            burst_q    <= '0;
            ram_rden_q <= 3'(1) << pick;
            state_q    <= ISSUE;
          end
        end
        ISSUE: state_q <= CAPTURE;
        CAPTURE: begin
          case (grant_q)
            2'd1:    out_data_q <= ram_q2;
            2'd2:    out_data_q <= ram_q3;
            default: out_data_q <= ram_q1;
          endcase
          out_port_q  <= grant_q;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            burst_q     <= burst_inc;
            if (burst_more) begin
              ram_rden_q <= 3'(1) << grant_q;
              state_q    <= ISSUE;
            end else begin
              last_q  <= grant_q;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_rden    = ram_rden_q;
  assign ram_rd_add1 = rd_ptr_q[0];
  assign ram_rd_add2 = rd_ptr_q[1];
  assign ram_rd_add3 = rd_ptr_q[2];
  assign out_data    = out_data_q;
  assign out_port    = out_port_q;
  assign out_valid   = out_valid_q;
  assign occupancy1  = cnt_q[0];
  assign occupancy2  = cnt_q[1];
  assign occupancy3  = cnt_q[2];
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ingress_arbiter.sv
// Testbench for ingress_arbiter: RAM models, a queue-based round-robin
// reference model and per-scenario tasks.
module tb_ingress_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int BURST  = 4;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [2:0]        push = 3'b000;
  logic [2:0]        ram_rden;
  logic [ADDR_W-1:0] ram_rd_add1, ram_rd_add2, ram_rd_add3;
  logic [DATA_W-1:0] ram_q1, ram_q2, ram_q3;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_port;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W:0]   occupancy1, occupancy2, occupancy3;
  logic [2:0]        overflow;

  ingress_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk(clk), .reset(reset), .enable(enable), .push(push),
    .ram_rden(ram_rden),
    .ram_rd_add1(ram_rd_add1), .ram_rd_add2(ram_rd_add2), .ram_rd_add3(ram_rd_add3),
    .ram_q1(ram_q1), .ram_q2(ram_q2), .ram_q3(ram_q3),
    .out_data(out_data), .out_port(out_port), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy1(occupancy1), .occupancy2(occupancy2), .occupancy3(occupancy3),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [3][DEPTH];
  logic [31:0] mq [3][$];
  logic [11:0] wr_ptr [3];
  int          model_last;
  int          obs_port [$];
  logic [31:0] obs_data [$];
  int          exp_port [$];
  logic [31:0] exp_data [$];
  int          rden_cnt = 0;
  int          onehot_err = 0;
  int          drop_err = 0;
  logic        prev_v = 1'b0, prev_hs = 1'b0, prev_rst = 1'b1;

  // Synchronous-read RAMs: data valid the cycle after rden
  always @(posedge clk) begin
    if (ram_rden[0]) ram_q1 <= mem[0][ram_rd_add1];
    if (ram_rden[1]) ram_q2 <= mem[1][ram_rd_add2];
    if (ram_rden[2]) ram_q3 <= mem[2][ram_rd_add3];
  end

  // Output monitor: records handshakes, read-enable pulses and invariants
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      obs_port.push_back(int'(out_port));
      obs_data.push_back(out_data);
    end
    if (ram_rden != 3'b000) rden_cnt <= rden_cnt + 1;
    if ($countones(ram_rden) > 1) onehot_err <= onehot_err + 1;
    if (prev_v && !prev_hs && !prev_rst && !out_valid) drop_err <= drop_err + 1;
    prev_v   <= out_valid;
    prev_hs  <= out_valid && out_ready;
    prev_rst <= reset;
  end

  task automatic clear_model();
    for (int p = 0; p < 3; p++) begin
      mq[p].delete();
      wr_ptr[p] = '0;
    end
    model_last = 2;
  endtask

  task automatic do_reset();
    reset = 1'b1; push = '0; enable = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  // Host write: store the word in the RAM model and pulse push for one edge
  task automatic push_multi(input logic [2:0] mask, input logic [31:0] d0,
                            input logic [31:0] d1, input logic [31:0] d2);
    logic [31:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int p = 0; p < 3; p++) begin
      if (mask[p] && mq[p].size() < DEPTH) begin
        mem[p][wr_ptr[p]] = d[p];
        wr_ptr[p] = wr_ptr[p] + 12'd1;
        mq[p].push_back(d[p]);
      end
    end
    push = mask;
    @(posedge clk);
    #1;
    push = '0;
  endtask

  // Reference: drain all pending words by round-robin bursts of up to BURST
  task automatic build_expected();
    int last, g, n;
    exp_port.delete();
    exp_data.delete();
    last = model_last;
    while (mq[0].size() + mq[1].size() + mq[2].size() > 0) begin
      g = -1;
      for (int k = 1; k <= 3; k++)
        if (g < 0 && mq[(last + k) % 3].size() > 0) g = (last + k) % 3;
      n = (mq[g].size() < BURST) ? mq[g].size() : BURST;
      for (int i = 0; i < n; i++) begin
        exp_port.push_back(g);
        exp_data.push_back(mq[g].pop_front());
      end
      last = g;
    end
    model_last = last;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_port !== 2'd0) begin
      failures++; $display("FAIL reset_out valid=%b data=%h port=%0d exp 0/0/0", out_valid, out_data, out_port); end
    checks++; if (ram_rden !== 3'b000) begin
      failures++; $display("FAIL reset_rden got=%b exp=000", ram_rden); end
    checks++; if (occupancy1 !== '0 || occupancy2 !== '0 || occupancy3 !== '0 || overflow !== 3'b000) begin
      failures++; $display("FAIL reset_occ occ=%0d/%0d/%0d ovf=%b exp 0/0/0 000", occupancy1, occupancy2, occupancy3, overflow); end
    checks++; if (ram_rd_add1 !== '0 || ram_rd_add2 !== '0 || ram_rd_add3 !== '0) begin
      failures++; $display("FAIL reset_addr got=%h/%h/%h exp 0", ram_rd_add1, ram_rd_add2, ram_rd_add3); end
  endtask

  task automatic test_single_latency();
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    push_multi(3'b001, 32'hA5A5_0001, 32'h0, 32'h0);   // edge N
    checks++; if (occupancy1 !== 13'd1 || ram_rden !== 3'b000) begin
      failures++; $display("FAIL lat_n occ1=%0d rden=%b exp 1 000", occupancy1, ram_rden); end
    @(posedge clk); #1;                                 // after N+1: ISSUE
    checks++; if (ram_rden !== 3'b001 || ram_rd_add1 !== 12'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL lat_n1 rden=%b add=%h valid=%b exp 001 0 0", ram_rden, ram_rd_add1, out_valid); end
    @(posedge clk); #1;                                 // after N+2: CAPTURE
    checks++; if (ram_rden !== 3'b000 || occupancy1 !== 13'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL lat_n2 rden=%b occ1=%0d valid=%b exp 000 0 0", ram_rden, occupancy1, out_valid); end
    @(posedge clk); #1;                                 // after N+3: HOLD
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || out_port !== 2'd0) begin
      failures++; $display("FAIL lat_n3 valid=%b data=%h port=%0d exp 1 a5a50001 0", out_valid, out_data, out_port); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || ram_rd_add1 !== 12'd1) begin
      failures++; $display("FAIL lat_n4 valid=%b add1=%h exp 0 001", out_valid, ram_rd_add1); end
    enable = 1'b0;
  endtask

  task automatic test_round_robin();
    int base, r0, t, nexp;
    do_reset();
    for (int i = 0; i < 6; i++) push_multi(3'b111, $urandom, $urandom, $urandom);
    build_expected();
    nexp = exp_port.size();
    base = obs_port.size(); r0 = rden_cnt;
    enable = 1'b1; out_ready = 1'b1;
    t = 0;
    while (obs_port.size() - base < nexp && t < 300) begin @(posedge clk); #1; t++; end
    checks++; if (obs_port.size() - base != nexp) begin
      failures++; $display("FAIL rr_count got=%0d exp=%0d", obs_port.size() - base, nexp); end
    else for (int i = 0; i < nexp; i++) begin
      checks++; if (obs_port[base+i] != exp_port[i] || obs_data[base+i] !== exp_data[i]) begin
        failures++; $display("FAIL rr_word%0d got=p%0d/%h exp=p%0d/%h", i, obs_port[base+i], obs_data[base+i], exp_port[i], exp_data[i]); end
    end
    checks++; if (rden_cnt - r0 != nexp || occupancy1 !== '0 || occupancy2 !== '0 || occupancy3 !== '0) begin
      failures++; $display("FAIL rr_drain rden=%0d occ=%0d/%0d/%0d exp %0d 0/0/0", rden_cnt - r0, occupancy1, occupancy2, occupancy3, nexp); end
    enable = 1'b0;
  endtask

  task automatic test_backpressure();
    int base, r0, r1, t;
    logic [31:0] d0;
    do_reset();
    for (int i = 0; i < 3; i++) push_multi(3'b010, 32'h0, $urandom, 32'h0);
    build_expected();
    base = obs_port.size(); r0 = rden_cnt;
    enable = 1'b1; out_ready = 1'b0;
    t = 0;
    while (out_valid !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    d0 = out_data; r1 = rden_cnt;
    checks++; if (out_valid !== 1'b1 || d0 !== exp_data[0] || out_port !== 2'd1) begin
      failures++; $display("FAIL bp_first valid=%b data=%h port=%0d exp 1 %h 1", out_valid, d0, out_port, exp_data[0]); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== d0 || out_port !== 2'd1 || rden_cnt != r1) begin
        failures++; $display("FAIL bp_hold%0d valid=%b data=%h port=%0d rden=%0d exp 1 %h 1 %0d", i, out_valid, out_data, out_port, rden_cnt, d0, r1); end
    end
    out_ready = 1'b1;
    t = 0;
    while (obs_port.size() - base < 3 && t < 30) begin @(posedge clk); #1; t++; end
    checks++; if (obs_port.size() - base != 3) begin
      failures++; $display("FAIL bp_count got=%0d exp=3", obs_port.size() - base); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (obs_port[base+i] != 1 || obs_data[base+i] !== exp_data[i]) begin
        failures++; $display("FAIL bp_word%0d got=p%0d/%h exp=p1/%h", i, obs_port[base+i], obs_data[base+i], exp_data[i]); end
    end
    checks++; if (rden_cnt - r0 != 3) begin
      failures++; $display("FAIL bp_rden got=%0d exp=3", rden_cnt - r0); end
    enable = 1'b0;
  endtask

  task automatic test_push_pop_enable();
    int base, r0, t;
    logic [31:0] a, b, c;
    do_reset();
    a = $urandom; b = $urandom; c = $urandom;
    push_multi(3'b100, 32'h0, 32'h0, a);
    push_multi(3'b100, 32'h0, 32'h0, b);
    base = obs_port.size(); r0 = rden_cnt;
    enable = 1'b1; out_ready = 1'b1;
    t = 0;
    while (ram_rden !== 3'b100 && t < 10) begin @(posedge clk); #1; t++; end
    checks++; if (ram_rden !== 3'b100 || occupancy3 !== 13'd2) begin
      failures++; $display("FAIL pp_issue rden=%b occ3=%0d exp 100 2", ram_rden, occupancy3); end
    push_multi(3'b100, 32'h0, 32'h0, c);   // coincides with the pop
    checks++; if (occupancy3 !== 13'd2) begin
      failures++; $display("FAIL pp_same occ3=%0d exp=2", occupancy3); end
    t = 0;
    while (ram_rden !== 3'b100 && t < 10) begin @(posedge clk); #1; t++; end
    enable = 1'b0;                          // drop during second word's ISSUE
    repeat (20) @(posedge clk);
    #1;
    checks++; if (obs_port.size() - base != 2 || rden_cnt - r0 != 2 || occupancy3 !== 13'd1) begin
      failures++; $display("FAIL en_drop words=%0d rden=%0d occ3=%0d exp 2 2 1", obs_port.size() - base, rden_cnt - r0, occupancy3); end
    else begin
      checks++; if (obs_port[base] != 2 || obs_data[base] !== a || obs_port[base+1] != 2 || obs_data[base+1] !== b) begin
        failures++; $display("FAIL en_words got=%h/%h exp=%h/%h", obs_data[base], obs_data[base+1], a, b); end
    end
    enable = 1'b1;
    t = 0;
    while (obs_port.size() - base < 3 && t < 20) begin @(posedge clk); #1; t++; end
    checks++; if (obs_port.size() - base != 3) begin
      failures++; $display("FAIL en_resume words=%0d exp=3", obs_port.size() - base); end
    else begin
      checks++; if (obs_port[base+2] != 2 || obs_data[base+2] !== c || occupancy3 !== 13'd0) begin
        failures++; $display("FAIL en_third got=p%0d/%h occ3=%0d exp=p2/%h 0", obs_port[base+2], obs_data[base+2], occupancy3, c); end
    end
    enable = 1'b0;
  endtask

  task automatic test_overflow();
    int base, t, errs;
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_multi(3'b010, 32'h0, $urandom, 32'h0);
    push_multi(3'b010, 32'h0, 32'hDEAD_BEEF, 32'h0);
    checks++; if (occupancy2 !== 13'd4096 || overflow !== 3'b010) begin
      failures++; $display("FAIL ovf_full occ2=%0d ovf=%b exp 4096 010", occupancy2, overflow); end
    build_expected();
    base = obs_port.size();
    enable = 1'b1; out_ready = 1'b1;
    t = 0;
    while (obs_port.size() - base < DEPTH && t < 14000) begin @(posedge clk); #1; t++; end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (obs_port.size() - base != DEPTH) begin
      failures++; $display("FAIL ovf_drain words=%0d exp=%0d", obs_port.size() - base, DEPTH); end
    else begin
      errs = 0;
      for (int i = 0; i < DEPTH; i++) begin
        checks++; if (obs_port[base+i] != exp_port[i] || obs_data[base+i] !== exp_data[i]) begin
          failures++; errs++;
          if (errs <= 8) $display("FAIL ovf_word%0d got=p%0d/%h exp=p%0d/%h", i, obs_port[base+i], obs_data[base+i], exp_port[i], exp_data[i]);
        end
      end
    end
    checks++; if (ram_rd_add2 !== 12'd0 || occupancy2 !== 13'd0 || overflow !== 3'b010) begin
      failures++; $display("FAIL ovf_wrap add2=%h occ2=%0d ovf=%b exp 000 0 010", ram_rd_add2, occupancy2, overflow); end
    enable = 1'b0;
  endtask

  task automatic test_reset_capture();
    int base, t, g;
    logic [31:0] x0, x2;
    enable = 1'b1; out_ready = 1'b1;
    g = -1;
    for (int k = 1; k <= 3; k++)
      if (g < 0 && ((model_last + k) % 3) != 0) g = (model_last + k) % 3;
    push_multi(3'b110, 32'h0, $urandom, $urandom);
    t = 0;
    while (ram_rden === 3'b000 && t < 10) begin @(posedge clk); #1; t++; end
    checks++; if (ram_rden !== 3'(1 << g)) begin
      failures++; $display("FAIL rc_grant rden=%b exp port %0d", ram_rden, g); end
    @(posedge clk); #1;                 // CAPTURE cycle
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || ram_rden !== 3'b000 || overflow !== 3'b000 ||
                  occupancy1 !== '0 || occupancy2 !== '0 || occupancy3 !== '0) begin
      failures++; $display("FAIL rc_state valid=%b rden=%b ovf=%b occ=%0d/%0d/%0d exp all 0", out_valid, ram_rden, overflow, occupancy1, occupancy2, occupancy3); end
    reset = 1'b0;
    clear_model();
    x0 = $urandom; x2 = $urandom;
    base = obs_port.size();
    push_multi(3'b101, x0, 32'h0, x2);
    t = 0;
    while (obs_port.size() - base < 2 && t < 30) begin @(posedge clk); #1; t++; end
    checks++; if (obs_port.size() - base != 2) begin
      failures++; $display("FAIL rc_count words=%0d exp=2", obs_port.size() - base); end
    else begin
      checks++; if (obs_port[base] != 0 || obs_data[base] !== x0 || obs_port[base+1] != 2 || obs_data[base+1] !== x2) begin
        failures++; $display("FAIL rc_order got=p%0d/%h p%0d/%h exp=p0/%h p2/%h", obs_port[base], obs_data[base], obs_port[base+1], obs_data[base+1], x0, x2); end
    end
    enable = 1'b0;
  endtask

  task automatic test_invariants();
    checks++; if (onehot_err != 0) begin
      failures++; $display("FAIL rden_onehot violations=%0d exp=0", onehot_err); end
    checks++; if (drop_err != 0) begin
      failures++; $display("FAIL valid_drop violations=%0d exp=0", drop_err); end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_round_robin();
    test_backpressure();
    test_push_pop_enable();
    test_overflow();
    test_reset_capture();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
